exers: RTL and testbench
========================

// Module: exers
// PURPOSE
//  Execution reservation station: receiving end of the rename->exers dispatch interface. Buffers
//  non-memory, non-CSR ops from rename, captures missing operands from the result broadcast bus,
//  and issues operand-complete ops to the integer execution unit. Drives exers_stall back to rename.
// PARAMETERS
//  DEPTH    8   number of entries (power of 2, >=2)
//  IDXW     3   log2(DEPTH)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous, active-high reset
//  rename_exers_write  in   1   dispatch request from rename
//  rename_op           in   5   op code
//  rename_robid        in   8   ROB id
//  rename_rd           in   6   destination
//  rename_op1ready     in   1   op1 holds value (1) or tag in [7:0] (0)
//  rename_op1          in   32  op1 value/tag
//  rename_op2ready     in   1   op2 holds value (1) or tag in [7:0] (0)
//  rename_op2          in   32  op2 value/tag
//  rename_imm          in   32  immediate
//  exers_stall         out  1   station full; dispatch not accepted
//  wb_valid            in   1   result broadcast valid
//  wb_robid            in   8   broadcast tag
//  wb_value            in   32  broadcast value
//  exers_issue_valid   out  1   issue request to execution unit
//  exu_ready           in   1   execution unit accepts this cycle
//  exers_issue_op/robid/rd/op1/op2/imm  out 5/8/6/32/32/32  issued entry fields
//  rob_flush           in   1   discard all entries
// BEHAVIOUR
//  - Entry state: valid, op, robid, rd, rdy1, val1, rdy2, val2, imm. Reset: all valid=0;
//    exers_stall=0, exers_issue_valid=0, issue data fields 0.
//  - exers_stall = all entries valid, from registered state only (no same-cycle issue credit;
//    avoids comb loop through rename). Rename holds its output while stalled, so:
//  - Accept = rename_exers_write & !exers_stall & !rob_flush. Accepted op goes to lowest-index free
//    entry at clock edge. Not accepted -> ignored (rename re-presents same op).
//  - Wakeup: each valid entry with rdyN=0 and valN[7:0]==wb_robid while wb_valid -> valN<=wb_value,
//    rdyN<=1. Bypass: accepted op with operand not ready and tag==wb_robid while wb_valid captures
//    wb_value and is written ready.
//  - Entry eligible when valid & rdy1 & rdy2. Select lowest-index eligible entry. exers_issue_valid
//    and issue fields are combinational from registered entries (zero-latency mux); minimum latency
//    write->issue = 1 cycle; wakeup->issue = 1 cycle after broadcast.
//  - Handshake: issue fires on exers_issue_valid & exu_ready; entry valid<=0 at that edge. With
//    !exu_ready the same entry stays presented unless a lower-index entry becomes eligible (data may change
//    while valid; execution unit samples only on fire).
//  - Simultaneous issue + accept in a full-minus-zero case: impossible (stall registered); freed entry
//    reusable from next cycle. Accept and issue of different entries same cycle: both take effect.
//  - rob_flush: exers_issue_valid forced 0 that cycle; all valid<=0 at edge; write and wakeup
//    ignored. rst has priority over everything; mid-operation rst drops all entries.
//  - No count arithmetic; full/free derived from valid vector. robid compare is exact 8-bit.
// TESTING
//  - Reset, then write op=3 robid=5 op1=10 op2=20 both ready, exu_ready=1 -> issue_valid next cycle
//    with op1=10 op2=20 robid=5; entry freed; issue_valid=0 after.
//  - Write robid=7 with op1 tag 0x04 not ready; 3 cycles later wb_valid robid=4 value=0xDEAD ->
//    issue next cycle, op1=0xDEAD.
//  - Write with op2 tag 0x09 in same cycle as wb robid=9 value=0x55 -> entry written ready, issues
//    next cycle with op2=0x55 (bypass).
//  - exu_ready=0, fill 8 ready ops -> exers_stall=1 after 8th; 9th write held, not stored; raise
//    exu_ready one cycle -> entry 0 issues, stall drops next cycle, 9th accepted into entry 0.
//  - 4 entries (2 waiting, 2 ready), assert rob_flush with write pending -> issue_valid=0 that cycle,
//    all entries empty next cycle, pending write not stored, later wakeup of old tags issues nothing.
//  - Assert rst with 5 entries valid -> next cycle stall=0, issue_valid=0, new write accepted to entry 0.

Source files
------------

// File: rtl/exers.sv
// rtl/exers.sv - execution reservation station between rename dispatch and the integer execution unit
module exers #(
   parameter int DEPTH = 8,
   parameter int IDXW  = 3
) (
   input  logic        clk,
   input  logic        rst,
   // dispatch from rename
   input  logic        rename_exers_write,
   input  logic [4:0]  rename_op,
   input  logic [7:0]  rename_robid,
   input  logic [5:0]  rename_rd,
   input  logic        rename_op1ready,
   input  logic [31:0] rename_op1,
   input  logic        rename_op2ready,
   input  logic [31:0] rename_op2,
   input  logic [31:0] rename_imm,
   output logic        exers_stall,
   // result broadcast bus
   input  logic        wb_valid,
   input  logic [7:0]  wb_robid,
   input  logic [31:0] wb_value,
   // issue to execution unit
   output logic        exers_issue_valid,
   input  logic        exu_ready,
   output logic [4:0]  exers_issue_op,
   output logic [7:0]  exers_issue_robid,
   output logic [5:0]  exers_issue_rd,
   output logic [31:0] exers_issue_op1,
   output logic [31:0] exers_issue_op2,
   output logic [31:0] exers_issue_imm,
   // pipeline flush
   input  logic        rob_flush
);

   // entry storage; an operand that is not ready holds its producer tag in [7:0]
   logic [DEPTH-1:0] ent_valid;
   logic [DEPTH-1:0] ent_rdy1;
   logic [DEPTH-1:0] ent_rdy2;
   logic [4:0]       ent_op    [DEPTH];
   logic [7:0]       ent_robid [DEPTH];
   logic [5:0]       ent_rd    [DEPTH];
   logic [31:0]      ent_val1  [DEPTH];
   logic [31:0]      ent_val2  [DEPTH];
   logic [31:0]      ent_imm   [DEPTH];

   logic [IDXW-1:0]  free_idx;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_any;
   logic [DEPTH-1:0] eligible;
   logic             accept;
   logic             fire;

   // operands of the incoming op after the same-cycle broadcast bypass
   logic             in_hit1;
   logic             in_hit2;
   logic             in_rdy1;
   logic             in_rdy2;
   logic [31:0]      in_val1;
   logic [31:0]      in_val2;

   // lowest-index free entry; only meaningful when the station is not full
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            free_idx = IDXW'(i);
         end
      end
   end

   // lowest-index entry whose operands are both present
   always_comb begin
      eligible = ent_valid & ent_rdy1 & ent_rdy2;
      sel_idx  = '0;
      sel_any  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_idx = IDXW'(i);
            sel_any = 1'b1;
         end
      end
   end

   // stall comes from registered state only so rename never sees a path through issue
   always_comb begin
      exers_stall = &ent_valid;
      accept      = rename_exers_write & ~exers_stall & ~rob_flush;
   end

   // capture a broadcast that matches an incoming operand tag in the same cycle
   always_comb begin
      in_hit1 = ~rename_op1ready & wb_valid & (rename_op1[7:0] == wb_robid);
      in_hit2 = ~rename_op2ready & wb_valid & (rename_op2[7:0] == wb_robid);
      in_rdy1 = rename_op1ready | in_hit1;
      in_rdy2 = rename_op2ready | in_hit2;
      in_val1 = in_hit1 ? wb_value : rename_op1;
      in_val2 = in_hit2 ? wb_value : rename_op2;
   end

   // issue mux straight off the entries; fields read zero whenever nothing is presented
   always_comb begin
      exers_issue_valid = sel_any & ~rob_flush;
      fire              = exers_issue_valid & exu_ready;
      exers_issue_op    = '0;
      exers_issue_robid = '0;
      exers_issue_rd    = '0;
      exers_issue_op1   = '0;
      exers_issue_op2   = '0;
      exers_issue_imm   = '0;
      if (exers_issue_valid) begin
         exers_issue_op    = ent_op[sel_idx];
         exers_issue_robid = ent_robid[sel_idx];
         exers_issue_rd    = ent_rd[sel_idx];
         exers_issue_op1   = ent_val1[sel_idx];
         exers_issue_op2   = ent_val2[sel_idx];
         exers_issue_imm   = ent_imm[sel_idx];
      end
   end

   // entry update: reset, flush, then wakeup / issue free / dispatch write per entry
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid <= '0;
         ent_rdy1  <= '0;
         ent_rdy2  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_op[i]    <= '0;
            ent_robid[i] <= '0;
            ent_rd[i]    <= '0;
            ent_val1[i]  <= '0;
            ent_val2[i]  <= '0;
            ent_imm[i]   <= '0;
         end
      end else if (rob_flush) begin
         ent_valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && wb_valid) begin
               if (!ent_rdy1[i] && (ent_val1[i][7:0] == wb_robid)) begin
                  ent_rdy1[i] <= 1'b1;
                  ent_val1[i] <= wb_value;
               end
               if (!ent_rdy2[i] && (ent_val2[i][7:0] == wb_robid)) begin
                  ent_rdy2[i] <= 1'b1;
                  ent_val2[i] <= wb_value;
               end
            end
            // the issued entry is valid and the written one is free, so these never collide
            if (fire && (sel_idx == IDXW'(i))) begin
               ent_valid[i] <= 1'b0;
            end
            if (accept && (free_idx == IDXW'(i))) begin
               ent_valid[i] <= 1'b1;
               ent_op[i]    <= rename_op;
               ent_robid[i] <= rename_robid;
               ent_rd[i]    <= rename_rd;
               ent_rdy1[i]  <= in_rdy1;
               ent_val1[i]  <= in_val1;
               ent_rdy2[i]  <= in_rdy2;
               ent_val2[i]  <= in_val2;
               ent_imm[i]   <= rename_imm;
            end
         end
      end
   end

endmodule

// File: tb/tb_exers.sv
// tb/tb_exers.sv - directed scoreboard bench for the exers reservation station
module tb_exers;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rename_exers_write = 1'b0;
   logic [4:0]  rename_op = '0;
   logic [7:0]  rename_robid = '0;
   logic [5:0]  rename_rd = '0;
   logic        rename_op1ready = 1'b0;
   logic [31:0] rename_op1 = '0;
   logic        rename_op2ready = 1'b0;
   logic [31:0] rename_op2 = '0;
   logic [31:0] rename_imm = '0;
   logic        exers_stall;
   logic        wb_valid = 1'b0;
   logic [7:0]  wb_robid = '0;
   logic [31:0] wb_value = '0;
   logic        exers_issue_valid;
   logic        exu_ready = 1'b0;
   logic [4:0]  exers_issue_op;
   logic [7:0]  exers_issue_robid;
   logic [5:0]  exers_issue_rd;
   logic [31:0] exers_issue_op1;
   logic [31:0] exers_issue_op2;
   logic [31:0] exers_issue_imm;
   logic        rob_flush = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  op;
      logic [7:0]  robid;
      logic [31:0] op1;
      logic [31:0] op2;
   } exp_t;

   exp_t sb[$];
   exp_t e9;

   exers dut (
      .clk                (clk),
      .rst                (rst),
      .rename_exers_write (rename_exers_write),
      .rename_op          (rename_op),
      .rename_robid       (rename_robid),
      .rename_rd          (rename_rd),
      .rename_op1ready    (rename_op1ready),
      .rename_op1         (rename_op1),
      .rename_op2ready    (rename_op2ready),
      .rename_op2         (rename_op2),
      .rename_imm         (rename_imm),
      .exers_stall        (exers_stall),
      .wb_valid           (wb_valid),
      .wb_robid           (wb_robid),
      .wb_value           (wb_value),
      .exers_issue_valid  (exers_issue_valid),
      .exu_ready          (exu_ready),
      .exers_issue_op     (exers_issue_op),
      .exers_issue_robid  (exers_issue_robid),
      .exers_issue_rd     (exers_issue_rd),
      .exers_issue_op1    (exers_issue_op1),
      .exers_issue_op2    (exers_issue_op2),
      .exers_issue_imm    (exers_issue_imm),
      .rob_flush          (rob_flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] op, input logic [7:0] robid,
                               input logic [31:0] op1, input logic [31:0] op2);
      exp_t e;
      e.op = op; e.robid = robid; e.op1 = op1; e.op2 = op2;
      return e;
   endfunction

   // rd and imm are derived from robid so every issued field is checkable
   task automatic dispatch(input logic [4:0] op, input logic [7:0] robid,
                           input logic r1, input logic [31:0] o1,
                           input logic r2, input logic [31:0] o2);
      rename_exers_write = 1'b1;
      rename_op          = op;
      rename_robid       = robid;
      rename_rd          = robid[5:0];
      rename_op1ready    = r1;
      rename_op1         = o1;
      rename_op2ready    = r2;
      rename_op2         = o2;
      rename_imm         = {24'h0, robid} ^ 32'hA5A5_0000;
   endtask

   // compare the presented issue against the oldest scoreboard entry
   task automatic check_issue(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {31'h0, exers_issue_valid}, 32'h1);
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_op"},    {27'h0, exers_issue_op},    {27'h0, e.op});
         chk({tag, "_robid"}, {24'h0, exers_issue_robid}, {24'h0, e.robid});
         chk({tag, "_rd"},    {26'h0, exers_issue_rd},    {26'h0, e.robid[5:0]});
         chk({tag, "_op1"},   exers_issue_op1,            e.op1);
         chk({tag, "_op2"},   exers_issue_op2,            e.op2);
         chk({tag, "_imm"},   exers_issue_imm,            {24'h0, e.robid} ^ 32'hA5A5_0000);
      end
   endtask

   initial begin
      // reset
      @(negedge clk);
      tick;
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'h0, exers_stall}, 32'h0);
      chk("rst_ivalid", {31'h0, exers_issue_valid}, 32'h0);
      chk("rst_op", {27'h0, exers_issue_op}, 32'h0);
      chk("rst_op1", exers_issue_op1, 32'h0);

      // single ready op issues one cycle after write
      exu_ready = 1'b1;
      dispatch(5'd3, 8'd5, 1'b1, 32'd10, 1'b1, 32'd20);
      sb.push_back(mk(5'd3, 8'd5, 32'd10, 32'd20));
      tick;
      rename_exers_write = 1'b0;
      check_issue("t1");
      tick;
      chk("t1_freed", {31'h0, exers_issue_valid}, 32'h0);

      // wakeup from the broadcast bus
      dispatch(5'd7, 8'd7, 1'b0, 32'h04, 1'b1, 32'd77);
      tick;
      rename_exers_write = 1'b0;
      chk("t2_wait0", {31'h0, exers_issue_valid}, 32'h0);
      tick;
      tick;
      chk("t2_wait2", {31'h0, exers_issue_valid}, 32'h0);
      wb_valid = 1'b1; wb_robid = 8'h04; wb_value = 32'hDEAD;
      sb.push_back(mk(5'd7, 8'd7, 32'hDEAD, 32'd77));
      tick;
      wb_valid = 1'b0;
      check_issue("t2");
      tick;
      chk("t2_freed", {31'h0, exers_issue_valid}, 32'h0);

      // same-cycle bypass on op2
      dispatch(5'd9, 8'h0A, 1'b1, 32'd1, 1'b0, 32'h09);
      wb_valid = 1'b1; wb_robid = 8'h09; wb_value = 32'h55;
      sb.push_back(mk(5'd9, 8'h0A, 32'd1, 32'h55));
      tick;
      rename_exers_write = 1'b0;
      wb_valid = 1'b0;
      check_issue("t3");
      tick;
      chk("t3_freed", {31'h0, exers_issue_valid}, 32'h0);

      // fill all entries while the execution unit is busy
      exu_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t4_nostall", {31'h0, exers_stall}, 32'h0);
         dispatch(5'(i + 1), 8'(8'h10 + i), 1'b1, 32'(i * 3 + 1), 1'b1, 32'(i * 5 + 2));
         sb.push_back(mk(5'(i + 1), 8'(8'h10 + i), 32'(i * 3 + 1), 32'(i * 5 + 2)));
         tick;
      end
      chk("t4_full", {31'h0, exers_stall}, 32'h1);
      chk("t4_head", {24'h0, exers_issue_robid}, 32'h10);
      dispatch(5'd30, 8'h20, 1'b1, 32'hAAAA, 1'b1, 32'hBBBB);
      e9 = mk(5'd30, 8'h20, 32'hAAAA, 32'hBBBB);
      tick;
      chk("t4_held", {31'h0, exers_stall}, 32'h1);
      check_issue("t4_e0");
      exu_ready = 1'b1;
      tick;
      exu_ready = 1'b0;
      chk("t4_drop", {31'h0, exers_stall}, 32'h0);
      chk("t4_next", {24'h0, exers_issue_robid}, 32'h11);
      tick;
      rename_exers_write = 1'b0;
      // the held op lands in freed entry 0 and so overtakes the older ones
      chk("t4_e9", {24'h0, exers_issue_robid}, 32'h20);
      sb.push_front(e9);
      exu_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_issue("t4_drain");
         tick;
      end
      chk("t4_empty", {31'h0, exers_issue_valid}, 32'h0);
      chk("t4_stall", {31'h0, exers_stall}, 32'h0);

      // flush with a write pending
      exu_ready = 1'b0;
      dispatch(5'd1, 8'h30, 1'b0, 32'h40, 1'b1, 32'd1);
      tick;
      dispatch(5'd2, 8'h31, 1'b1, 32'd2, 1'b0, 32'h41);
      tick;
      dispatch(5'd3, 8'h32, 1'b1, 32'd3, 1'b1, 32'd3);
      tick;
      dispatch(5'd4, 8'h33, 1'b1, 32'd4, 1'b1, 32'd4);
      tick;
      chk("t5_pre", {24'h0, exers_issue_robid}, 32'h32);
      dispatch(5'd5, 8'h34, 1'b1, 32'd5, 1'b1, 32'd5);
      rob_flush = 1'b1;
      #1;
      chk("t5_ivalid_flush", {31'h0, exers_issue_valid}, 32'h0);
      tick;
      rob_flush = 1'b0;
      rename_exers_write = 1'b0;
      exu_ready = 1'b1;
      #1;
      chk("t5_empty", {31'h0, exers_issue_valid}, 32'h0);
      chk("t5_stall", {31'h0, exers_stall}, 32'h0);
      wb_valid = 1'b1; wb_robid = 8'h40; wb_value = 32'h1234;
      tick;
      wb_robid = 8'h41;
      tick;
      wb_valid = 1'b0;
      chk("t5_stale1", {31'h0, exers_issue_valid}, 32'h0);
      tick;
      chk("t5_stale2", {31'h0, exers_issue_valid}, 32'h0);

      // reset in the middle of operation
      exu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dispatch(5'd6, 8'(8'h50 + i), 1'b1, 32'd6, 1'b1, 32'd6);
         tick;
      end
      rename_exers_write = 1'b0;
      chk("t6_pre", {24'h0, exers_issue_robid}, 32'h50);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("t6_stall", {31'h0, exers_stall}, 32'h0);
      chk("t6_ivalid", {31'h0, exers_issue_valid}, 32'h0);
      chk("t6_robid", {24'h0, exers_issue_robid}, 32'h0);
      dispatch(5'd12, 8'h60, 1'b1, 32'h600, 1'b1, 32'h601);
      sb.push_back(mk(5'd12, 8'h60, 32'h600, 32'h601));
      tick;
      rename_exers_write = 1'b0;
      exu_ready = 1'b1;
      check_issue("t6");
      tick;
      chk("t6_empty", {31'h0, exers_issue_valid}, 32'h0);
      chk("sb_drained", sb.size(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
